// File: rtl/led_frame_writer.sv
// rtl/led_frame_writer.sv - double-buffered pixel write front end for the red/green LED matrix driver
//
// Purpose:
//   Game logic draws into a back buffer (per-pixel writes, bulk clear), then
//   commits. The back buffer is copied to the front buffer in a single edge on
//   the driver's next frame_sync, so the scanner never sees a half-drawn frame.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous active-low reset
//   wr_valid       pixel write request (wr_x, wr_y, wr_color)
//   wr_ready       high only in IDLE; write/clear/commit accepted this cycle
//   clr_valid      clear whole back buffer (one row per cycle)
//   commit         publish back buffer at next frame_sync
//   frame_sync     driver pulse at start of row 0 scan
//   commit_pending commit accepted, copy not yet done
//   RedPixels      front red plane   [y][x]
//   GrnPixels      front green plane [y][x]
//   frame_count    (only with FRAME_COUNT_EN) number of front copies, mod 256
//
// Optional feature macro: FRAME_COUNT_EN

module led_frame_writer #(
   parameter int ROWS = 16,
   parameter int COLS = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [$clog2(COLS)-1:0]       wr_x,
   input  logic [$clog2(ROWS)-1:0]       wr_y,
   input  logic [1:0]                    wr_color,
   input  logic                          clr_valid,
   input  logic                          commit,
   input  logic                          frame_sync,
   output logic                          commit_pending,
`ifdef FRAME_COUNT_EN
   output logic [7:0]                    frame_count,
`endif
   output logic [ROWS-1:0][COLS-1:0]     RedPixels,
   output logic [ROWS-1:0][COLS-1:0]     GrnPixels
);

   localparam int RW = $clog2(ROWS);

   typedef enum logic [1:0] {IDLE, CLEAR, WAIT_SYNC} state_t;

   state_t                   state_q, state_d;
   logic [RW-1:0]            clr_row_q, clr_row_d;
   logic                     pend_q, pend_d;
   logic [ROWS-1:0][COLS-1:0] back_red_q, back_red_d;
   logic [ROWS-1:0][COLS-1:0] back_grn_q, back_grn_d;
   logic [ROWS-1:0][COLS-1:0] front_red_q, front_red_d;
   logic [ROWS-1:0][COLS-1:0] front_grn_q, front_grn_d;
`ifdef FRAME_COUNT_EN
   logic [7:0]               fcnt_q, fcnt_d;
`endif

   logic in_range;

   // Out-of-range coordinates still complete the handshake; they just write nothing.
   assign in_range = (int'(wr_x) < COLS) && (int'(wr_y) < ROWS);

   always_comb begin
      state_d     = state_q;
      clr_row_d   = clr_row_q;
      pend_d      = pend_q;
      back_red_d  = back_red_q;
      back_grn_d  = back_grn_q;
      front_red_d = front_red_q;
      front_grn_d = front_grn_q;
`ifdef FRAME_COUNT_EN
      fcnt_d      = fcnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (clr_valid) begin
               // Clear wins outright; a same-cycle write or commit is dropped.
               state_d   = CLEAR;
               clr_row_d = '0;
            end else begin
               // Write lands before a same-cycle commit so it is part of the frame.
               if (wr_valid && in_range) begin
                  back_red_d[wr_y][wr_x] = wr_color[0];
                  back_grn_d[wr_y][wr_x] = wr_color[1];
               end
               // frame_sync is deliberately not looked at here: a sync coinciding
               // with the commit must not swap.
               if (commit) begin
                  state_d = WAIT_SYNC;
                  pend_d  = 1'b1;
               end
            end
         end
         CLEAR: begin
            back_red_d[clr_row_q] = '0;
            back_grn_d[clr_row_q] = '0;
            if (clr_row_q == RW'(ROWS - 1)) begin
               state_d = IDLE;
            end else begin
               clr_row_d = clr_row_q + RW'(1);
            end
         end
         WAIT_SYNC: begin
            if (frame_sync) begin
               // Back buffer is left intact so drawing can continue incrementally.
               front_red_d = back_red_q;
               front_grn_d = back_grn_q;
               pend_d      = 1'b0;
               state_d     = IDLE;
`ifdef FRAME_COUNT_EN
               fcnt_d      = fcnt_q + 8'd1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         clr_row_q   <= '0;
         pend_q      <= 1'b0;
         back_red_q  <= '0;
         back_grn_q  <= '0;
         front_red_q <= '0;
         front_grn_q <= '0;
`ifdef FRAME_COUNT_EN
         fcnt_q      <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         clr_row_q   <= clr_row_d;
         pend_q      <= pend_d;
         back_red_q  <= back_red_d;
         back_grn_q  <= back_grn_d;
         front_red_q <= front_red_d;
         front_grn_q <= front_grn_d;
`ifdef FRAME_COUNT_EN
         fcnt_q      <= fcnt_d;
`endif
      end
   end

   // Ready is decoded from state (not registered) so it reads 1 while reset is low.
   assign wr_ready       = (state_q == IDLE);
   assign commit_pending = pend_q;
   assign RedPixels      = front_red_q;
   assign GrnPixels      = front_grn_q;
`ifdef FRAME_COUNT_EN
   assign frame_count    = fcnt_q;
`endif

endmodule
